unit_splitter: RTL and testbench
================================

# unit_splitter

Demultiplexer on the write-back side of the matrix datapath: accepts one full row (`DATA_SIZE*COLUMN_SIZE` bits) per handshake and routes it to either the row buffer or the matrix unit input, as selected per beat. It holds one beat in a registered stage with independent valid/ready on each destination. It generates the buffer write address, wrapping at `BUF_DEPTH`, and flags the last row of each matrix tile.

## Interface
- `DATA_SIZE`, 16, bit width of one element
- `COLUMN_SIZE`, 64, elements per row; `W = DATA_SIZE*COLUMN_SIZE`
- `BUF_DEPTH`, 16, rows in the buffer; buffer address wraps modulo this value (≥2)
- `ADDR_WIDTH`, 4, width of `buf_addr`; must satisfy `2**ADDR_WIDTH >= BUF_DEPTH`
- `ROW_SIZE`, 64, rows per matrix tile; `mat_last` marks every `ROW_SIZE`-th matrix beat (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear of the held beat and both counters
- `selector`  in  1  sampled with `datsIn` on accept: 1 routes to buffer, 0 routes to matrix
- `datsIn`  in  W  input row
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  splitter can accept this cycle
- `out_buffer`  out  W  row to buffer
- `buf_valid`  out  1  `out_buffer` and `buf_addr` valid
- `buf_ready`  in  1  buffer accepts
- `buf_addr`  out  ADDR_WIDTH  buffer write address of the presented beat
- `out_matrix`  out  W  row to matrix unit
- `mat_valid`  out  1  `out_matrix` valid
- `mat_ready`  in  1  matrix unit accepts
- `mat_last`  out  1  presented matrix beat is the last row of a tile

## Operation
- One holding register `hold[W-1:0]` drives both `out_buffer` and `out_matrix`. Only the valid signals distinguish the destination.
- States:
  - EMPTY: nothing held.
  - FULL_BUF: `buf_valid=1`.
  - FULL_MAT: `mat_valid=1`.
  - `buf_valid` and `mat_valid` are never both 1.
- Output fire: `fire_out = (FULL_BUF & buf_ready) | (FULL_MAT & mat_ready)`.
- `in_ready = rst_n & ~clear & (EMPTY | fire_out)`. The path from downstream ready to `in_ready` is combinational, which allows back-to-back transfers.
- Accept is `in_valid & in_ready`. On accept, `hold <= datsIn`, and the next state is FULL_BUF if `selector=1`, else FULL_MAT.
- If `fire_out` occurs without an accept, the next state is EMPTY.
- Held data, destination and `buf_addr` remain stable while valid is high and ready is low.
- Buffer counter `bcnt`:
  - Drives `buf_addr`.
  - Increments on a buffer fire.
  - Wraps from `BUF_DEPTH-1` to 0.
- Matrix counter `mcnt`:
  - Increments on a matrix fire.
  - Wraps from `ROW_SIZE-1` to 0.
  - `mat_last = FULL_MAT & (mcnt == ROW_SIZE-1)`.
- `clear`:
  - The next state is EMPTY, and `bcnt` and `mcnt` are set to 0.
  - Any held beat is dropped. No fire counts in that cycle, even if downstream ready is high.
  - `clear` has priority over accept (`in_ready` is 0).
- `ROW_SIZE=1`: `mat_last=1` on every matrix beat.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State EMPTY; `hold=0`; `bcnt=0`; `mcnt=0`.
  - `buf_valid=mat_valid=mat_last=0`, `buf_addr=0`, `out_buffer=out_matrix=0`.
  - `in_ready=0` while `rst_n` is low and 1 in the first cycle after release.
- Latency: a beat accepted at edge N is presented with valid high from edge N through edge N+1.
- Throughput is 1 beat per cycle when the selected destination holds ready high.
- Simultaneous fire and accept: the held beat leaves and the new beat loads at the same edge. The destination may switch (buffer→matrix) with no bubble.
- Counters update only on their own destination's fire, never on accept.
- Reset asserted mid-transfer: the held beat is lost and all outputs go to their reset values immediately.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1` → `in_ready=0` and all valids 0. After release: `in_ready=1`, `buf_addr=0`.
- Alternate routing: send rows 0xA…, 0xB… with `selector=1,0,1` and both readies high.
  - Expected outputs each cycle: `buf_valid` with `buf_addr=0`, then `mat_valid`, then `buf_valid` with `buf_addr=1`.
  - No bubbles.
- Backpressure: `buf_ready=0` for 5 cycles with `in_valid=1`.
  - Expected: `in_ready=0`; `out_buffer` and `buf_addr` stable.
  - Expected after `buf_ready` rises: the beat fires once, and the next beat loads at the same edge.
- Wrap: with `BUF_DEPTH=16`, send 17 buffer beats → `buf_addr` sequence is 0..15, 0.
- Tile last: with `ROW_SIZE=4`, send 8 matrix beats → `mat_last=1` on beats 4 and 8 only.
- Clear:
  - Setup: hold a matrix beat with `mcnt=2` and `bcnt=3`.
  - Stimulus: pulse `clear` while `mat_ready=1`.
  - Expected: no fire counted; next cycle is EMPTY with `buf_addr=0`; the next matrix beat has `mat_last=0` and is counted as row 0.

Source files
------------

// File: rtl/unit_splitter.sv
// unit_splitter: write-back demultiplexer. One registered holding stage takes a
// full row per handshake and presents it to either the row buffer (with a
// wrapping write address) or the matrix unit (with a tile-last flag).
module unit_splitter #(
   parameter int DATA_SIZE   = 16,
   parameter int COLUMN_SIZE = 64,
   parameter int BUF_DEPTH   = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int ROW_SIZE    = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             selector,
   input  logic [DATA_SIZE*COLUMN_SIZE-1:0] datsIn,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_SIZE*COLUMN_SIZE-1:0] out_buffer,
   output logic                             buf_valid,
   input  logic                             buf_ready,
   output logic [ADDR_WIDTH-1:0]            buf_addr,
   output logic [DATA_SIZE*COLUMN_SIZE-1:0] out_matrix,
   output logic                             mat_valid,
   input  logic                             mat_ready,
   output logic                             mat_last
);

   localparam int W      = DATA_SIZE * COLUMN_SIZE;
   // Keep the row counter at least one bit wide so ROW_SIZE=1 still elaborates.
   localparam int MCNT_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam logic [ADDR_WIDTH-1:0] BUF_MAX  = ADDR_WIDTH'(BUF_DEPTH - 1);
   localparam logic [MCNT_W-1:0]     MCNT_MAX = MCNT_W'(ROW_SIZE - 1);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FULL_BUF = 2'd1,
      FULL_MAT = 2'd2
   } state_t;

   state_t                 state_reg;
   state_t                 state_next;
   logic [ADDR_WIDTH-1:0]  bcnt_reg;
   logic [MCNT_W-1:0]      mcnt_reg;
   logic [DATA_SIZE-1:0]   lane_reg [COLUMN_SIZE];
   logic [W-1:0]           hold;

   logic fire_buf;
   logic fire_mat;
   logic fire_out;
   logic accept;

   // A fire during clear is dropped: the held beat is discarded, not delivered.
   assign fire_buf = (state_reg == FULL_BUF) & buf_ready & ~clear;
   assign fire_mat = (state_reg == FULL_MAT) & mat_ready & ~clear;
   assign fire_out = fire_buf | fire_mat;

   // Downstream ready feeds straight through so a new beat can load as the old one leaves.
   assign in_ready = rst_n & ~clear & ((state_reg == EMPTY) | fire_out);
   assign accept   = in_valid & in_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: clear wins, then a new beat, then drain to empty on fire
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = EMPTY;
      end else if (accept) begin
         state_next = selector ? FULL_BUF : FULL_MAT;
      end else if (fire_out) begin
         state_next = EMPTY;
      end
   end

   // Output decode from the held destination
   always_comb begin
      buf_valid = 1'b0;
      mat_valid = 1'b0;
      mat_last  = 1'b0;
      case (state_reg)
         FULL_BUF: buf_valid = 1'b1;
         FULL_MAT: begin
            mat_valid = 1'b1;
            mat_last  = (mcnt_reg == MCNT_MAX);
         end
         default: ;
      endcase
   end

   // Buffer write address advances only when a buffer beat actually leaves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_reg <= '0;
      end else if (clear) begin
         bcnt_reg <= '0;
      end else if (fire_buf) begin
         bcnt_reg <= (bcnt_reg == BUF_MAX) ? '0 : bcnt_reg + 1'b1;
      end
   end

   // Row-within-tile counter advances only when a matrix beat actually leaves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt_reg <= '0;
      end else if (clear) begin
         mcnt_reg <= '0;
      end else if (fire_mat) begin
         mcnt_reg <= (mcnt_reg == MCNT_MAX) ? '0 : mcnt_reg + 1'b1;
      end
   end

   // Holding register, one element lane per column
   generate
      for (genvar gi = 0; gi < COLUMN_SIZE; gi++) begin : g_lane
         // Capture this column's element on every accepted beat
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lane_reg[gi] <= '0;
            end else if (accept) begin
               lane_reg[gi] <= datsIn[gi*DATA_SIZE +: DATA_SIZE];
            end
         end
         assign hold[gi*DATA_SIZE +: DATA_SIZE] = lane_reg[gi];
      end
   endgenerate

   // Both destinations see the same row; only the valids say who owns it.
   assign out_buffer = hold;
   assign out_matrix = hold;
   assign buf_addr   = bcnt_reg;

endmodule

// File: tb/tb_unit_splitter.sv
// Directed testbench for unit_splitter with a narrow row (4 x 8 bits),
// BUF_DEPTH=16 and ROW_SIZE=4. Inputs change on the falling edge; outputs are
// checked on the falling edge (or #1 after an input change).
module tb_unit_splitter;

   localparam int DATA_SIZE   = 8;
   localparam int COLUMN_SIZE = 4;
   localparam int BUF_DEPTH   = 16;
   localparam int ADDR_WIDTH  = 4;
   localparam int ROW_SIZE    = 4;
   localparam int W           = DATA_SIZE * COLUMN_SIZE;

   logic                  clk;
   logic                  rst_n;
   logic                  clear;
   logic                  selector;
   logic [W-1:0]          datsIn;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          out_buffer;
   logic                  buf_valid;
   logic                  buf_ready;
   logic [ADDR_WIDTH-1:0] buf_addr;
   logic [W-1:0]          out_matrix;
   logic                  mat_valid;
   logic                  mat_ready;
   logic                  mat_last;

   int n_vec = 0;
   int n_err = 0;

   unit_splitter #(
      .DATA_SIZE   (DATA_SIZE),
      .COLUMN_SIZE (COLUMN_SIZE),
      .BUF_DEPTH   (BUF_DEPTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ROW_SIZE    (ROW_SIZE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .selector   (selector),
      .datsIn     (datsIn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_buffer (out_buffer),
      .buf_valid  (buf_valid),
      .buf_ready  (buf_ready),
      .buf_addr   (buf_addr),
      .out_matrix (out_matrix),
      .mat_valid  (mat_valid),
      .mat_ready  (mat_ready),
      .mat_last   (mat_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Advance one clock: through the rising edge to the next falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic sel, input logic [W-1:0] d);
      in_valid = v;
      selector = sel;
      datsIn   = d;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; buf_ready = 1'b1; mat_ready = 1'b1;
      drive(1'b1, 1'b1, 32'hDEAD_BEEF);

      // ---- reset with in_valid high ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst in_ready",   in_ready,   0);
      check_val("rst buf_valid",  buf_valid,  0);
      check_val("rst mat_valid",  mat_valid,  0);
      check_val("rst mat_last",   mat_last,   0);
      check_val("rst buf_addr",   buf_addr,   0);
      check_val("rst out_buffer", out_buffer, 0);
      drive(1'b0, 1'b0, '0);
      rst_n = 1'b1;
      #1;
      check_val("post-rst in_ready", in_ready, 1);
      check_val("post-rst buf_addr", buf_addr, 0);

      // ---- alternate routing buf, mat, buf ----
      drive(1'b1, 1'b1, 32'hA000_0000);
      cycle();
      check_val("alt0 buf_valid", buf_valid, 1);
      check_val("alt0 mat_valid", mat_valid, 0);
      check_val("alt0 buf_addr",  buf_addr,  0);
      check_val("alt0 data",      out_buffer, 32'hA000_0000);
      drive(1'b1, 1'b0, 32'hB000_0000);
      #1;
      check_val("alt0 in_ready", in_ready, 1);
      cycle();
      check_val("alt1 mat_valid", mat_valid, 1);
      check_val("alt1 buf_valid", buf_valid, 0);
      check_val("alt1 data",      out_matrix, 32'hB000_0000);
      check_val("alt1 mat_last",  mat_last, 0);
      drive(1'b1, 1'b1, 32'hA000_0001);
      cycle();
      check_val("alt2 buf_valid", buf_valid, 1);
      check_val("alt2 buf_addr",  buf_addr,  1);
      check_val("alt2 data",      out_buffer, 32'hA000_0001);
      drive(1'b0, 1'b0, '0);
      cycle();
      check_val("alt drain buf_valid", buf_valid, 0);
      check_val("alt drain mat_valid", mat_valid, 0);
      // bcnt=2, mcnt=1

      // ---- clear setup: one matrix beat, one buffer beat, then hold a matrix beat ----
      drive(1'b1, 1'b0, 32'hD000_0000);
      cycle();
      drive(1'b1, 1'b1, 32'hD000_0001);
      cycle();
      check_val("setup buf_addr", buf_addr, 2);
      drive(1'b1, 1'b0, 32'hD000_0002);
      mat_ready = 1'b0;
      cycle();
      drive(1'b0, 1'b0, '0);
      #1;
      check_val("setup mat_valid", mat_valid, 1);
      check_val("setup mat_last",  mat_last,  0);
      check_val("setup data",      out_matrix, 32'hD000_0002);
      check_val("setup buf_addr",  buf_addr,  3);

      // ---- clear pulse with mat_ready high and a competing beat ----
      drive(1'b1, 1'b0, 32'hE000_0000);
      mat_ready = 1'b1;
      clear = 1'b1;
      #1;
      check_val("clear in_ready", in_ready, 0);
      cycle();
      clear = 1'b0;
      drive(1'b0, 1'b0, '0);
      #1;
      check_val("clear mat_valid", mat_valid, 0);
      check_val("clear buf_valid", buf_valid, 0);
      check_val("clear buf_addr",  buf_addr,  0);
      check_val("clear in_ready after", in_ready, 1);

      // ---- tile last: 8 matrix beats, first one counted as row 0 after clear ----
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'hF000_0000 + 32'(i));
         cycle();
         check_val($sformatf("tile%0d mat_valid", i), mat_valid, 1);
         check_val($sformatf("tile%0d data", i), out_matrix, 32'hF000_0000 + 32'(i));
         check_val($sformatf("tile%0d mat_last", i), mat_last, (i == 3 || i == 7) ? 1 : 0);
      end
      drive(1'b0, 1'b0, '0);
      cycle();
      check_val("tile drain mat_valid", mat_valid, 0);

      // ---- address wrap: 17 buffer beats back to back ----
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, 32'h0100_0000 + 32'(i));
         cycle();
         check_val($sformatf("wrap%0d buf_valid", i), buf_valid, 1);
         check_val($sformatf("wrap%0d buf_addr", i), buf_addr, i % 16);
      end
      drive(1'b0, 1'b0, '0);
      cycle();
      // bcnt=1

      // ---- backpressure on the buffer side ----
      drive(1'b1, 1'b1, 32'hC000_0000);
      cycle();
      buf_ready = 1'b0;
      drive(1'b1, 1'b1, 32'hC000_0001);
      #1;
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("bp%0d in_ready", i), in_ready, 0);
         check_val($sformatf("bp%0d buf_valid", i), buf_valid, 1);
         check_val($sformatf("bp%0d data", i), out_buffer, 32'hC000_0000);
         check_val($sformatf("bp%0d buf_addr", i), buf_addr, 1);
         cycle();
      end
      buf_ready = 1'b1;
      #1;
      check_val("bp release in_ready", in_ready, 1);
      cycle();
      check_val("bp next data",     out_buffer, 32'hC000_0001);
      check_val("bp next buf_addr", buf_addr, 2);
      check_val("bp next buf_valid", buf_valid, 1);
      drive(1'b0, 1'b0, '0);
      cycle();
      check_val("bp drain buf_valid", buf_valid, 0);
      check_val("bp drain buf_addr",  buf_addr, 3);

      // ---- reset mid-transfer ----
      buf_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h5555_AAAA);
      cycle();
      check_val("midrst pre buf_valid", buf_valid, 1);
      rst_n = 1'b0;
      #1;
      check_val("midrst buf_valid",  buf_valid, 0);
      check_val("midrst out_buffer", out_buffer, 0);
      check_val("midrst buf_addr",   buf_addr, 0);
      check_val("midrst in_ready",   in_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
